// File: rtl/conv_arb_pkg.sv
// Shared types and constants for the conv_arbiter block.
package conv_arb_pkg;

   // Width of one converter code {a,b,c,d}
   localparam int CODE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: the first asserted request after the
// pointer position (wrapping modulo NREQ) wins.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req_valid,
   input  logic [IW-1:0]   i_rr_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);

   // Walk ptr+1, ptr+2, ... ptr+NREQ and keep the first hit
   always_comb begin
      // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!o_any && i_req_valid[IW'((int'(i_rr_ptr) + k) % NREQ)]) begin
            o_any = 1'b1;
            o_grant[IW'((int'(i_rr_ptr) + k) % NREQ)] = 1'b1;
            o_idx = IW'((int'(i_rr_ptr) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/conv_arbiter.sv
// Round-robin arbiter sharing one combinational code converter among NREQ
// requesters. One transaction in flight: grant, hold conv_in for CONV_LAT
// cycles, capture conv_out, return it with the requester id.
// Optional build macro CONV_ARB_STATS_EN adds saturating per-requester grant
// counters on output grant_cnt.
module conv_arbiter
   import conv_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int CONV_LAT = 1
`ifdef CONV_ARB_STATS_EN
   ,
   parameter int CNTW     = 8
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*CODE_W-1:0]     req_data,
   output logic [NREQ-1:0]            req_ready,
   output logic                       resp_valid,
   output logic [$clog2(NREQ)-1:0]    resp_id,
   output logic [CODE_W-1:0]          resp_data,
   input  logic                       resp_ready,
   output logic [CODE_W-1:0]          conv_in,
   input  logic [CODE_W-1:0]          conv_out,
`ifdef CONV_ARB_STATS_EN
   output logic [NREQ*CNTW-1:0]       grant_cnt,
`endif
   output logic                       busy
);

   localparam int IW  = $clog2(NREQ);
   localparam int WCW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IW-1:0]       r_rr_ptr;
   logic [IW-1:0]       r_id;
   logic [WCW-1:0]      r_wait_cnt;
   logic [CODE_W-1:0]   r_conv_in;
   logic                r_resp_valid;
   logic [IW-1:0]       r_resp_id;
   logic [CODE_W-1:0]   r_resp_data;

   logic [NREQ-1:0]     w_grant;
   logic [IW-1:0]       w_idx;
   logic                w_any;
   logic                w_accept;
   logic                w_done;
   logic                w_hs;
   logic [CODE_W-1:0]   w_code;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .i_req_valid (req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .o_grant     (w_grant),
      .o_idx       (w_idx),
      .o_any       (w_any)
   );

   // Select the winning requester's code
   always_comb begin
      w_code = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_idx == IW'(i)) w_code = req_data[i*CODE_W +: CODE_W];
      end
   end

   // Next-state logic plus the combinational handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_hs        = 1'b0;
      req_ready   = '0;
      busy        = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (w_any) begin
               req_ready   = w_grant;
               w_accept    = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (r_wait_cnt == '0) begin
               w_done      = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               w_hs        = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Datapath: launch code, count hold cycles, capture and return result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr     <= IW'(NREQ - 1);
         r_id         <= '0;
         r_wait_cnt   <= '0;
         r_conv_in    <= '0;
         r_resp_valid <= 1'b0;
         r_resp_id    <= '0;
         r_resp_data  <= '0;
      end else begin
         if (w_accept) begin
            r_conv_in  <= w_code;
            r_id       <= w_idx;
            r_wait_cnt <= WCW'(CONV_LAT - 1);
         end else if (r_state == WAIT && !w_done) begin
            r_wait_cnt <= r_wait_cnt - WCW'(1);
         end
         if (w_done) begin
            r_resp_data  <= conv_out;
            r_resp_id    <= r_id;
            r_resp_valid <= 1'b1;
         end
         if (w_hs) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= r_id;
         end
      end
   end

   assign conv_in    = r_conv_in;
   assign resp_valid = r_resp_valid;
   assign resp_id    = r_resp_id;
   assign resp_data  = r_resp_data;

`ifdef CONV_ARB_STATS_EN
   logic [CNTW-1:0] r_grant_cnt [NREQ];

   // Saturating per-requester accept counters
   always_ff @(posedge clk) begin
      // NOTE: this small counter bank is cleared by rst because its values are architectural; a RAM would not be.
      if (rst) begin
         for (int i = 0; i < NREQ; i++) r_grant_cnt[i] <= '0;
      end else if (w_accept && (r_grant_cnt[w_idx] != '1)) begin
         r_grant_cnt[w_idx] <= r_grant_cnt[w_idx] + CNTW'(1);
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
      assign grant_cnt[g*CNTW +: CNTW] = r_grant_cnt[g];
   end
`endif

endmodule

// File: tb/tb_conv_arbiter.sv
// Self-checking bench for conv_arbiter: directed scenarios plus random
// traffic, scored against a transaction-level model of the arbiter.
module tb_conv_arbiter;

   localparam int NREQ     = 4;
   localparam int CONV_LAT = 1;
   localparam int CNTW     = 2;
   localparam int CNT_MAX  = (1 << CNTW) - 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*4-1:0]    req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 resp_valid;
   logic [1:0]           resp_id;
   logic [3:0]           resp_data;
   logic                 resp_ready;
   logic [3:0]           conv_in;
   logic [3:0]           conv_out;
   logic                 busy;

   logic [NREQ-1:0]      req_valid3;
   logic [NREQ*4-1:0]    req_data3;
   logic [NREQ-1:0]      req_ready3;
   logic                 resp_valid3;
   logic [1:0]           resp_id3;
   logic [3:0]           resp_data3;
   logic                 resp_ready3;
   logic [3:0]           conv_in3;
   logic [3:0]           conv_out3;
   logic                 busy3;
`ifdef CONV_ARB_STATS_EN
   logic [NREQ*CNTW-1:0] grant_cnt;
   logic [NREQ*8-1:0]    grant_cnt3;
`endif

   always #5 clk = ~clk;

   // Converter stubs
   assign conv_out  = ~conv_in;
   assign conv_out3 = ~conv_in3;

   conv_arbiter #(
      .NREQ     (NREQ),
      .CONV_LAT (CONV_LAT)
`ifdef CONV_ARB_STATS_EN
      ,
      .CNTW     (CNTW)
`endif
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .conv_in    (conv_in),
      .conv_out   (conv_out),
`ifdef CONV_ARB_STATS_EN
      .grant_cnt  (grant_cnt),
`endif
      .busy       (busy)
   );

   conv_arbiter #(
      .NREQ     (NREQ),
      .CONV_LAT (3)
   ) u_dut3 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid3),
      .req_data   (req_data3),
      .req_ready  (req_ready3),
      .resp_valid (resp_valid3),
      .resp_id    (resp_id3),
      .resp_data  (resp_data3),
      .resp_ready (resp_ready3),
      .conv_in    (conv_in3),
      .conv_out   (conv_out3),
`ifdef CONV_ARB_STATS_EN
      .grant_cnt  (grant_cnt3),
`endif
      .busy       (busy3)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int         id;
      logic [3:0] data;
   } resp_t;

   resp_t           sb_q[$];
   int              grant_log[$];
   logic [3:0]      data_log[$];
   bit              m_busy = 1'b0;
   int              m_age = 0;
   int              m_last = NREQ - 1;
   logic [3:0]      m_conv_in = 4'h0;
   bit              m_just_reset = 1'b0;
   int              m_cnt[NREQ];
   logic [NREQ-1:0] m_grant_prev = '0;
   logic [NREQ-1:0] exp_ready;
   bit              exp_valid;
   int              win;
   logic [3:0]      win_code;
   resp_t           new_rec;

   // Model: one request in flight; response appears CONV_LAT+1 cycles after accept
   always @(negedge clk) begin
      if (rst) begin
         m_busy       = 1'b0;
         m_last       = NREQ - 1;
         m_conv_in    = 4'h0;
         m_just_reset = 1'b1;
         m_grant_prev = '0;
         sb_q.delete();
         for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      end else begin
         if (m_busy) m_age++;
         exp_valid = m_busy && (m_age >= CONV_LAT + 1);
         exp_ready = '0;
         win       = -1;
         if (!m_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (win < 0 && req_valid[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
            end
         end
         if (win >= 0) exp_ready[win] = 1'b1;
         check("req_ready", req_ready, exp_ready);
         check("busy", busy, m_busy);
         check("resp_valid", resp_valid, exp_valid);
         check("conv_in", conv_in, m_conv_in);
         if (m_just_reset) begin
            check("rst_resp_id", resp_id, 0);
            check("rst_resp_data", resp_data, 0);
            m_just_reset = 1'b0;
         end
         if (exp_valid && sb_q.size() > 0) check("resp_hold", resp_data, sb_q[0].data);
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
         if (exp_valid && resp_ready) m_busy = 1'b0;
         if (win >= 0) begin
            win_code     = req_data[win*4 +: 4];
            new_rec.id   = win;
            new_rec.data = ~win_code;
            sb_q.push_back(new_rec);
            m_busy    = 1'b1;
            m_age     = 0;
            m_last    = win;
            m_conv_in = win_code;
            if (m_cnt[win] < CNT_MAX) m_cnt[win]++;
         end
         m_grant_prev = exp_ready;
      end
   end

   // Monitor: score every response handshake against the queue
   resp_t got_exp;
   always @(negedge clk) begin
      if (!rst && resp_valid && resp_ready) begin
         check("resp_expected", sb_q.size() > 0, 1);
         if (sb_q.size() > 0) begin
            got_exp = sb_q.pop_front();
            check("resp_id", resp_id, got_exp.id);
            check("resp_data", resp_data, got_exp.data);
            data_log.push_back(resp_data);
         end
      end
   end

   // Hard bound on run time
   initial begin
      #1_000_000;
      $display("FAIL watchdog: no finish by %0t", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   int exp_ord[5];
   logic [3:0] exp_dat[5];

   initial begin
      exp_ord = '{0, 1, 2, 3, 0};
      exp_dat = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
      rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b0;
      req_valid3 = '0; req_data3 = '0; resp_ready3 = 1'b0;
      step(); step();
      do_reset();

      // CONV_LAT=3 instance: latency and conv_in stability
      req_valid3 = 4'b0001; req_data3 = 16'h0005; resp_ready3 = 1'b1;
      @(negedge clk);
      check("l3_ready", req_ready3, 4'b0001);
      step();
      req_valid3 = '0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check("l3_conv_in", conv_in3, 4'h5);
         check("l3_valid_low", resp_valid3, 0);
         check("l3_busy", busy3, 1);
      end
      @(negedge clk);
      check("l3_valid", resp_valid3, 1);
      check("l3_data", resp_data3, 4'hA);
      check("l3_id", resp_id3, 0);
      @(negedge clk);
      check("l3_valid_after", resp_valid3, 0);
      check("l3_conv_hold", conv_in3, 4'h5);
      check("l3_idle", busy3, 0);
      step();

      // Single requester after reset
      req_valid = 4'b0001; req_data = 16'h0003; resp_ready = 1'b1;
      step();
      req_valid = '0;
      repeat (4) step();

      // All four requesting: rotation 0,1,2,3,0
      do_reset();
      grant_log.delete(); data_log.delete();
      req_valid = 4'b1111; req_data = 16'h8421; resp_ready = 1'b1;
      repeat (13) step();
      req_valid = '0;
      repeat (4) step();
      check("order_len", grant_log.size(), 5);
      check("data_len", data_log.size(), 5);
      for (int i = 0; i < 5; i++) begin
         check("order", grant_log[i], exp_ord[i]);
         check("order_data", data_log[i], exp_dat[i]);
      end

      // Consumer stalls in RESP; other requesters must wait
      req_valid = 4'b0100; req_data = 16'h0600; resp_ready = 1'b0;
      step();
      req_valid = 4'b0011; req_data = 16'h0659;
      repeat (6) step();
      resp_ready = 1'b1;
      step();
      req_valid = '0;
      repeat (8) step();

      // Reset in WAIT aborts the transaction; requester 0 wins next
      req_valid = 4'b0001; req_data = 16'h0009;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      grant_log.delete();
      req_valid = 4'b1111; req_data = 16'h8421;
      step();
      check("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
      req_valid = '0;
      repeat (4) step();

      // Random traffic
      for (int cyc = 0; cyc < 2000; cyc++) begin
         resp_ready = ($urandom_range(0, 2) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && m_grant_prev[i]) begin
               if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
            end else if (req_valid[i]) begin
               if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               req_valid[i]        = 1'b1;
               req_data[i*4 +: 4]  = 4'($urandom_range(0, 15));
            end
         end
         step();
      end
      req_valid = '0; resp_ready = 1'b1;
      repeat (10) step();
      check("sb_empty", sb_q.size(), 0);
      check("busy_end", busy, 0);

`ifdef CONV_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) check("grant_cnt_model", grant_cnt[i*CNTW +: CNTW], m_cnt[i]);
      do_reset();
      req_valid = 4'b0100; req_data = 16'h0100; resp_ready = 1'b1;
      repeat (13) step();
      req_valid = '0;
      repeat (4) step();
      check("grant_cnt_sat", grant_cnt, 8'b00_11_00_00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
